clap_conditioner: RTL and testbench
===================================

Name: clap_conditioner

Overview:
- Front-end for the clap-controlled laser path. Converts the raw digital output of the sound-sensor comparator into one clean, fixed-width pulse per clap.
- Feeds the clap-counting stage, whose `aplauso` input it drives.
- Synchronises the async sensor input and rejects glitches shorter than a minimum width.
- Applies a lockout window so that acoustic ringing and comparator chatter from a single clap never produce a second pulse.

Parameters:
- MIC_ACTIVE_HIGH, 1, 1: sensor asserts high on sound; 0: sensor asserts low (input inverted after sync).
- MIN_HIGH_CYC, 500, consecutive active cycles required to qualify a clap (10 us @ 50 MHz); must be >= 1.
- PULSE_CYC, 50_000, width of the output pulse in cycles (1 ms); must be >= 1.
- LOCKOUT_CYC, 2_500_000, quiet time after the pulse ends before a new clap is accepted (50 ms). Must keep PULSE_CYC+LOCKOUT_CYC < 5_000_000 so a second clap after 100 ms is never masked.
- CNT_W, 27, width of the shared timer; must hold max(MIN_HIGH_CYC, PULSE_CYC, LOCKOUT_CYC).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- mic_raw  in  1  raw sensor comparator output, asynchronous to clk.
- aplauso  out  1  clean clap pulse, registered; high for exactly PULSE_CYC cycles per accepted clap.
- busy  out  1  high in QUALIFY, PULSE and LOCKOUT.
- clap_count  out  8  accepted claps since reset; saturates at 255.

Behaviour:
- Reset (rst_n=0, async): sync flops = inactive level; state=IDLE; timer=0; aplauso=0; busy=0; clap_count=0.
- Sync: 2-FF synchroniser on mic_raw, then polarity fix. `act` = synchronised active level; input-to-`act` latency = 2 cycles.
- Single timer, reloaded to 0 on every state change.
- IDLE:
  - act=1 -> QUALIFY, timer=1.
- QUALIFY:
  - act=0 -> IDLE (glitch rejected; no count, no pulse).
  - act=1 and timer==MIN_HIGH_CYC-1 -> PULSE. aplauso=1 starting the next cycle; clap_count+1 (saturating).
  - Otherwise timer+1.
  - MIN_HIGH_CYC=1: qualify in the first QUALIFY cycle.
- PULSE:
  - aplauso=1; act ignored.
  - timer==PULSE_CYC-1 -> LOCKOUT; aplauso=0 from the next cycle.
- LOCKOUT:
  - aplauso=0.
  - Any act=1 cycle restarts the timer at 0 (chatter extends lockout).
  - timer==LOCKOUT_CYC-1 with act=0 -> IDLE.
- Input continuously active: block stays in LOCKOUT; no second pulse until act has been low for LOCKOUT_CYC consecutive cycles.
- Total latency from first active mic_raw edge to aplauso rise = 2 + MIN_HIGH_CYC + 1 cycles.
- busy = (state != IDLE), registered alongside the state.
- Outputs are all registered; no combinational path from mic_raw to any output.
- Reset asserted mid-pulse: aplauso drops immediately (async); after release, block restarts in IDLE.

Decomposition:
- Shared package `laser_pkg`:
  - State enum: IDLE, QUALIFY, PULSE, LOCKOUT.
  - CLK_HZ = 50_000_000.
  - Default timing constants, also used by the clap-counting stage (100 ms = 5_000_000, 2 s = 100_000_000).
- One natural sub-module: `sync_2ff` (parameterised reset value, async active-low reset), reused by other async-input paths.
- FSM and timer stay in clap_conditioner.

Test Plan:
Sim params: MIN_HIGH_CYC=4, PULSE_CYC=8, LOCKOUT_CYC=20.
- Glitch reject: mic_raw high 3 cycles then low -> aplauso stays 0, clap_count=0, busy high for ≤4 cycles then low.
- Clean clap: mic_raw high 10 cycles -> aplauso rises 7 cycles after the mic_raw edge, stays high exactly 8 cycles, clap_count=1.
- Chatter: after the clap, toggle mic_raw every 3 cycles for 30 cycles -> no second pulse; IDLE reached 20 quiet cycles after the last active sample; clap_count=1.
- Double clap: two 10-cycle bursts, second starting 60 cycles after the first -> two 8-cycle pulses, clap_count=2.
- Polarity: MIC_ACTIVE_HIGH=0, mic_raw low 10 cycles -> one pulse; mic_raw held high -> none.
- Reset mid-PULSE: drop rst_n on the 3rd pulse cycle -> aplauso=0 the same cycle, count=0; after release plus a 10-cycle burst -> normal pulse.
- Saturation: 300 clean claps -> clap_count=255.

Source files
------------

// File: rtl/laser_pkg.sv
// Shared definitions for the clap-controlled laser path: conditioner states and
// default timing constants at the 50 MHz system clock.
package laser_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    PULSE   = 2'd2,
    LOCKOUT = 2'd3
  } clap_state_t;

  localparam int unsigned CLK_HZ = 50_000_000;

  localparam int unsigned MIN_HIGH_CYC_DEF = 500;          // 10 us
  localparam int unsigned PULSE_CYC_DEF    = 50_000;       // 1 ms
  localparam int unsigned LOCKOUT_CYC_DEF  = 2_500_000;    // 50 ms

  // Used by the clap-counting stage downstream
  localparam int unsigned CLAP_GAP_CYC     = 5_000_000;    // 100 ms
  localparam int unsigned CLAP_WINDOW_CYC  = 100_000_000;  // 2 s

  function automatic int unsigned ms_to_cyc(input int unsigned ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reset value selects
// the level seen downstream while rst_n is low.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= RST_VAL;
      sync_reg <= RST_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/clap_conditioner.sv
// Turns the raw sound-sensor comparator output into one fixed-width pulse per
// clap, with glitch rejection and a chatter-extended lockout window.
module clap_conditioner
  import laser_pkg::*;
#(
  parameter int MIC_ACTIVE_HIGH = 1,
  parameter int MIN_HIGH_CYC    = 500,
  parameter int PULSE_CYC       = 50_000,
  parameter int LOCKOUT_CYC     = 2_500_000,
  parameter int CNT_W           = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mic_raw,
  output logic       aplauso,
  output logic       busy,
  output logic [7:0] clap_count
);

  localparam logic MIC_IDLE_LVL = (MIC_ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;
  localparam logic [CNT_W-1:0] MIN_LAST   = CNT_W'(MIN_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCKOUT_CYC - 1);

  logic             mic_sync;
  logic             act;
  clap_state_t      state_reg, state_next;
  logic [CNT_W-1:0] timer_reg, timer_next;
  logic             count_inc;
  logic             aplauso_reg;
  logic             busy_reg;
  logic [7:0]       clap_count_reg;

  sync_2ff #(
    .RST_VAL (MIC_IDLE_LVL)
  ) u_mic_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (mic_raw),
    .q     (mic_sync)
  );

  assign act = (MIC_ACTIVE_HIGH != 0) ? mic_sync : ~mic_sync;

  // The IDLE cycle that sees act counts as the first qualifying cycle, hence
  // the timer starts at 1 on entry to QUALIFY.
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    count_inc  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (act) begin
          state_next = QUALIFY;
          timer_next = CNT_W'(1);
        end
      end
      QUALIFY: begin
        if (!act) begin
          state_next = IDLE;
          timer_next = '0;
        end else if (timer_reg >= MIN_LAST) begin
          state_next = PULSE;
          timer_next = '0;
          count_inc  = 1'b1;
        end else begin
          timer_next = timer_reg + CNT_W'(1);
        end
      end
      PULSE: begin
        if (timer_reg == PULSE_LAST) begin
          state_next = LOCKOUT;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + CNT_W'(1);
        end
      end
      LOCKOUT: begin
        if (act) begin
          timer_next = '0;
        end else if (timer_reg == LOCK_LAST) begin
          state_next = IDLE;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  // aplauso follows the PULSE state by one cycle so the whole output stays
  // registered and the pulse keeps exactly PULSE_CYC cycles of width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      aplauso_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      clap_count_reg <= '0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      aplauso_reg <= (state_reg == PULSE);
      busy_reg    <= (state_next != IDLE);
      if (count_inc && (clap_count_reg != 8'hFF)) begin
        clap_count_reg <= clap_count_reg + 8'd1;
      end
    end
  end

  assign aplauso    = aplauso_reg;
  assign busy       = busy_reg;
  assign clap_count = clap_count_reg;

endmodule

// File: tb/tb_clap_conditioner.sv
// Directed and random checks of clap_conditioner against a cycle-level
// behavioural model; an active-low instance receives the inverted stimulus.
module tb_clap_conditioner;

  localparam int MIN_C = 4;
  localparam int PUL_C = 8;
  localparam int LCK_C = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mic = 1'b0;
  logic       mic_l;
  logic       ap_h, busy_h, ap_l, busy_l;
  logic [7:0] cnt_h, cnt_l;

  assign mic_l = ~mic;

  always #5 clk = ~clk;

  clap_conditioner #(
    .MIC_ACTIVE_HIGH (1), .MIN_HIGH_CYC (MIN_C), .PULSE_CYC (PUL_C),
    .LOCKOUT_CYC (LCK_C), .CNT_W (27)
  ) dut_h (
    .clk (clk), .rst_n (rst_n), .mic_raw (mic),
    .aplauso (ap_h), .busy (busy_h), .clap_count (cnt_h)
  );

  clap_conditioner #(
    .MIC_ACTIVE_HIGH (0), .MIN_HIGH_CYC (MIN_C), .PULSE_CYC (PUL_C),
    .LOCKOUT_CYC (LCK_C), .CNT_W (27)
  ) dut_l (
    .clk (clk), .rst_n (rst_n), .mic_raw (mic_l),
    .aplauso (ap_l), .busy (busy_l), .clap_count (cnt_l)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Behavioural model, in active-high terms
  bit h1, h2;          // mic samples still in flight through the synchroniser
  int run;             // consecutive active samples while qualifying (0 = not qualifying)
  int pulse_left;      // pulse cycles still owed
  bit locking;
  int quiet;           // consecutive quiet samples during lockout
  bit m_ap, m_busy;
  int m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    h1 = 0; h2 = 0; run = 0; pulse_left = 0; locking = 0; quiet = 0;
    m_ap = 0; m_busy = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    bit a;
    a = h2; h2 = h1; h1 = mic;
    m_ap = (pulse_left > 0);
    if (pulse_left > 0) begin
      pulse_left--;
      if (pulse_left == 0) begin locking = 1; quiet = 0; end
    end else if (locking) begin
      quiet = a ? 0 : quiet + 1;
      if (quiet == LCK_C) locking = 0;
    end else if (run > 0) begin
      if (!a) run = 0;
      else if (run + 1 >= MIN_C) begin
        run = 0; pulse_left = PUL_C;
        if (m_cnt < 255) m_cnt++;
      end else run++;
    end else if (a) begin
      run = 1;
    end
    m_busy = (run > 0) || (pulse_left > 0) || locking;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_edge();
    cyc++;
    #1;
    check("aplauso_h", ap_h, m_ap);
    check("busy_h", busy_h, m_busy);
    check("count_h", cnt_h, m_cnt);
    check("aplauso_l", ap_l, m_ap);
    check("busy_l", busy_l, m_busy);
    check("count_l", cnt_l, m_cnt);
  endtask

  int rise, width, busy_hi, last_hi, idle_cyc, base, rises;

  initial begin
    model_reset();
    // Reset state
    repeat (3) tick();
    #2 rst_n = 1'b1;
    repeat (2) tick();

    // Glitch: 3 active cycles are rejected
    busy_hi = 0;
    mic = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i == 3) mic = 1'b0;
      tick();
      if (busy_h) busy_hi++;
    end
    check("glitch_busy_le4", busy_hi <= 4, 1);
    check("glitch_count", cnt_h, 0);

    // Clean clap: 10 active cycles, then chatter during lockout
    rise = -1; width = 0;
    for (int i = 0; i < 20; i++) begin
      mic = (i < 10);
      tick();
      if (ap_h && rise < 0) rise = i + 1;
      if (ap_h) width++;
    end
    check("clap_latency", rise, 2 + MIN_C + 1);
    check("clap_width", width, PUL_C);
    check("clap_count1", cnt_h, 1);

    width = 0; last_hi = 0;
    for (int j = 0; j < 30; j++) begin
      mic = ((j / 3) % 2 == 0);
      tick();
      if (mic) last_hi = cyc;
      if (ap_h) width++;
    end
    mic = 1'b0;
    idle_cyc = -1;
    for (int k = 0; k < 60 && idle_cyc < 0; k++) begin
      tick();
      if (!busy_h) idle_cyc = cyc;
    end
    check("chatter_no_pulse", width, 0);
    check("chatter_idle_cycle", idle_cyc, last_hi + 2 + LCK_C);
    check("chatter_count", cnt_h, 1);

    // Double clap, second burst 60 cycles after the first
    base = cnt_h; rises = 0; width = 0;
    for (int i = 0; i < 130; i++) begin
      mic = (i < 10) || (i >= 60 && i < 70);
      tick();
      if (ap_h) width++;
      if (ap_h && width % PUL_C == 1) rises++;
    end
    mic = 1'b0;
    check("double_pulses", rises, 2);
    check("double_width", width, 2 * PUL_C);
    check("double_count", cnt_h, base + 2);

    // Active-low instance sees a held inactive (high) input: no claps
    base = cnt_l;
    repeat (50) tick();
    check("polarity_hold_count", cnt_l, base);
    check("polarity_match", cnt_l, cnt_h);

    // Reset in the 3rd pulse cycle
    rise = -1;
    mic = 1'b1;
    for (int i = 0; i < 30 && rise < 0; i++) begin
      if (i == 10) mic = 1'b0;
      tick();
      if (ap_h) rise = i;
    end
    check("rst_pulse_seen", rise >= 0, 1);
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_ap_h", ap_h, 0);
    check("rst_ap_l", ap_l, 0);
    check("rst_count", cnt_h, 0);
    check("rst_busy", busy_h, 0);
    mic = 1'b0;
    repeat (2) tick();
    #2 rst_n = 1'b1;
    repeat (10) tick();
    rise = -1; width = 0;
    for (int i = 0; i < 20; i++) begin
      mic = (i < 10);
      tick();
      if (ap_h && rise < 0) rise = i + 1;
      if (ap_h) width++;
    end
    check("post_rst_latency", rise, 2 + MIN_C + 1);
    check("post_rst_width", width, PUL_C);
    check("post_rst_count", cnt_h, 1);

    // Random segments
    for (int s = 0; s < 60; s++) begin
      mic = ~mic;
      repeat ($urandom_range(1, 25)) tick();
    end
    mic = 1'b0;
    repeat (40) tick();

    // Saturation
    for (int c = 0; c < 300; c++) begin
      mic = 1'b1;
      repeat (6) tick();
      mic = 1'b0;
      repeat (40) tick();
    end
    check("sat_count_h", cnt_h, 255);
    check("sat_count_l", cnt_l, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
